dec_pipe: RTL
=============

DEC_PIPE -- requirements
Module: dec_pipe

Interface
REQ-001 SHALL have parameter MAX_CODEWORD_WIDTH, default 32, maximum codeword width; legal values 8, 16, 32.
REQ-002 SHALL have parameter MAX_INFO_WIDTH, default 26, maximum information width.
REQ-003 SHALL have parameter AMBA_WORD, default 32, work_mod width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, error-statistics counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  input codeword present.
REQ-009 in_ready  output  1  block accepts the input codeword this cycle.
REQ-010 data_in  input  MAX_CODEWORD_WIDTH  received codeword, LSB-aligned.
REQ-011 work_mod  input  AMBA_WORD  mode per transaction: 0 = 8-bit code (4 info bits), 1 = 16-bit code (11 info bits), 2 = 32-bit code (26 info bits).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 data_out  output  MAX_CODEWORD_WIDTH  corrected information bits, zero-padded at the MSBs.
REQ-015 num_of_errors  output  2  0 = clean, 1 = corrected, 2 = uncorrectable, 3 = illegal mode.
REQ-016 stat_clr  input  1  clears the statistics counters.
REQ-017 cnt_single / cnt_double  output  CNT_WIDTH each  saturating counts of corrected and uncorrectable codewords.

Function
REQ-018 A transfer SHALL occur on a cycle where in_valid && in_ready; data_in and work_mod SHALL be captured together and travel with the transaction.
REQ-019 The block SHALL be a 2-stage pipeline. Stage 1 registers the syndrome, the overall-parity bit, the mode and the codeword. Stage 2 registers the corrected info, num_of_errors and out_valid.
REQ-020 Latency SHALL be exactly 2 cycles from an accepted input to out_valid with no backpressure; throughput SHALL be one codeword per cycle.
REQ-021 Stall: when out_valid && !out_ready, both stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-022 A result SHALL be held stable (data_out, num_of_errors) while out_valid && !out_ready.
REQ-023 Bits of data_in above the active mode's codeword length SHALL be ignored.
REQ-024 Error classification:
- syndrome == 0 -> num_of_errors 0, info output as received;
- overall parity odd -> num_of_errors 1, the bit addressed by the syndrome is flipped (an overall-parity-bit-only error is also 1, with info unchanged);
- syndrome != 0 and overall parity even -> num_of_errors 2, info output uncorrected.
REQ-025 A work_mod value other than 0/1/2, or a mode whose code exceeds MAX_CODEWORD_WIDTH, SHALL yield num_of_errors 3 and data_out 0, and SHALL still consume one slot.
REQ-026 The parity-check matrix for each mode SHALL be identical to that of the team's encoder.
REQ-027 The counters SHALL increment on the output handshake (out_valid && out_ready) only, and SHALL saturate at all-ones.
REQ-028 If stat_clr and an increment occur in the same cycle, clear SHALL win.

Reset
REQ-029 On rst, the stage valids, out_valid, data_out, num_of_errors and both counters SHALL be 0. in_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions with no output produced.

Configuration
REQ-031 With DEC_PIPE_ERR_STATS_EN defined, the counters and stat_clr logic SHALL be compiled in.
REQ-032 Without DEC_PIPE_ERR_STATS_EN, the ports SHALL remain, cnt_single and cnt_double SHALL be tied to 0, and stat_clr SHALL be ignored.

Structure
REQ-033 Package dec_pipe_pkg SHALL hold the mode encodings, per-mode info/parity/codeword lengths, the H-matrix constants and the num_of_errors enum.
REQ-034 The combinational syndrome and overall-parity computation SHALL be a sub-module, dec_syndrome.

Verification
REQ-035 Mode 0, data_in 0x00, out_ready=1 -> 2 cycles later out_valid=1, data_out 0, num_of_errors 0.
REQ-036 Mode 2, all-zero codeword with bit 7 flipped -> data_out 0, num_of_errors 1, and cnt_single increments to 1.
REQ-037 Mode 1, all-zero codeword with bits 3 and 9 flipped -> num_of_errors 2, cnt_double = 1.
REQ-038 work_mod 5 -> data_out 0, num_of_errors 3, counters unchanged.
REQ-039 Back-to-back stream of 4 codewords with out_ready held 0 for 3 cycles -> in_ready=0 during the stall, and all 4 outputs arrive in order with no loss or duplication.
REQ-040 rst asserted with 2 codewords in flight -> no out_valid afterwards; counters 0.

Source files
------------

// File: rtl/dec_pipe_pkg.sv
// Shared types and code tables for the SECDED decoder pipeline.
// Codeword bit p (1..n-1) is Hamming position p; bit 0 is the overall parity bit.
package dec_pipe_pkg;

    localparam int WORD_W = 32;
    localparam int SYN_W  = 5;

    typedef enum logic [1:0] {
        MODE_8   = 2'd0,
        MODE_16  = 2'd1,
        MODE_32  = 2'd2,
        MODE_BAD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2,
        ERR_MODE   = 2'd3
    } err_e;

    // Check-bit positions: overall parity at 0, Hamming parity at powers of two.
    // H column for position p is {1'b1, p}, matching the encoder.
    localparam logic [WORD_W-1:0] PARITY_POS_MASK = 32'h0001_0117;

    function automatic int cw_len(input mode_e m);
        case (m)
            MODE_8:  return 8;
            MODE_16: return 16;
            MODE_32: return 32;
            default: return 0;
        endcase
    endfunction

    function automatic int info_len(input mode_e m);
        case (m)
            MODE_8:  return 4;
            MODE_16: return 11;
            MODE_32: return 26;
            default: return 0;
        endcase
    endfunction

    // Includes the overall parity bit.
    function automatic int par_len(input mode_e m);
        case (m)
            MODE_8:  return 4;
            MODE_16: return 5;
            MODE_32: return 6;
            default: return 0;
        endcase
    endfunction

    // Packs the non-check positions below n, ascending, into the info LSBs.
    function automatic logic [WORD_W-1:0] extract_info(input logic [WORD_W-1:0] cw, input int n);
        logic [WORD_W-1:0] info;
        int k;
        info = '0;
        k    = 0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < n && !PARITY_POS_MASK[i]) begin
                info[k[SYN_W-1:0]] = cw[i];
                k++;
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Combinational syndrome and overall parity over the active codeword length.
// Bits at or above the mode's length are ignored; MODE_BAD yields zeros.
module dec_syndrome
    import dec_pipe_pkg::*;
(
    input  logic [WORD_W-1:0] cw,
    input  mode_e             mode,
    output logic [SYN_W-1:0]  syndrome,
    output logic              parity
);

    int n;

    always_comb begin
        n        = cw_len(mode);
        syndrome = '0;
        parity   = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < n && cw[i]) begin
                parity   = ~parity;
                syndrome = syndrome ^ i[SYN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dec_pipe.sv
// Two-stage SECDED decoder, 2-cycle latency, one codeword per cycle; a held result stalls both stages.
// Error statistics counters are present only with DEC_PIPE_ERR_STATS_EN defined.
module dec_pipe
    import dec_pipe_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          stat_clr,
    output logic [CNT_WIDTH-1:0]          cnt_single,
    output logic [CNT_WIDTH-1:0]          cnt_double
);

    logic              stall;
    logic              wm_legal;
    mode_e             in_mode;
    logic [WORD_W-1:0] in_cw;
    logic [SYN_W-1:0]  in_syn;
    logic              in_par;

    logic              s1_vld;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_par;
    mode_e             s1_mode;
    logic [WORD_W-1:0] s1_cw;

    logic [WORD_W-1:0] fix_cw;
    logic [WORD_W-1:0] nxt_info;
    err_e              nxt_err;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign wm_legal = (work_mod <= AMBA_WORD'(2))
                   && (cw_len(mode_e'(work_mod[1:0])) <= MAX_CODEWORD_WIDTH);
    assign in_mode  = wm_legal ? mode_e'(work_mod[1:0]) : MODE_BAD;

    always_comb begin
        in_cw                           = '0;
        in_cw[MAX_CODEWORD_WIDTH-1:0]   = data_in;
    end

    dec_syndrome u_syn (
        .cw       (in_cw),
        .mode     (in_mode),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    // Odd parity with zero syndrome flips bit 0, the overall parity bit, so info is unchanged.
    always_comb begin
        fix_cw   = s1_cw;
        nxt_err  = ERR_NONE;
        nxt_info = '0;
        if (s1_mode == MODE_BAD) begin
            nxt_err = ERR_MODE;
        end else begin
            if (s1_par) begin
                nxt_err          = ERR_SINGLE;
                fix_cw[s1_syn]   = ~s1_cw[s1_syn];
            end else if (s1_syn != '0) begin
                nxt_err = ERR_DOUBLE;
            end
            nxt_info = extract_info(fix_cw, cw_len(s1_mode));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld        <= 1'b0;
            s1_syn        <= '0;
            s1_par        <= 1'b0;
            s1_mode       <= MODE_8;
            s1_cw         <= '0;
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= ERR_NONE;
        end else if (!stall) begin
            s1_vld    <= in_valid;
            out_valid <= s1_vld;
            if (in_valid) begin
                s1_syn  <= in_syn;
                s1_par  <= in_par;
                s1_mode <= in_mode;
                s1_cw   <= in_cw;
            end
            if (s1_vld) begin
                data_out      <= nxt_info[MAX_CODEWORD_WIDTH-1:0];
                num_of_errors <= nxt_err;
            end
        end
    end

`ifdef DEC_PIPE_ERR_STATS_EN
    logic hs;
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (hs) begin
            if (num_of_errors == ERR_SINGLE && cnt_single != '1) begin
                cnt_single <= cnt_single + 1'b1;
            end
            if (num_of_errors == ERR_DOUBLE && cnt_double != '1) begin
                cnt_double <= cnt_double + 1'b1;
            end
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign cnt_single      = '0;
    assign cnt_double      = '0;
`endif

endmodule
